aes256_enc_round_ctrl: RTL and testbench

- Control FSM that sequences the AES-256 encryption round datapath: subBytes, shiftRows, mixColumns and addRoundKey stage registers.
- Issues one-cycle write-enable strobes to each stage, selects the addRoundKey data source and round-key index, and skips mixColumns in the final round.
- Sits between the top-level start/result handshake and the stage modules. Each stage captures on its wr_en and presents its result continuously from the next cycle.

---
 rtl/aes_enc_pkg.sv | 24 ++
 rtl/aes256_enc_round_ctrl_if.sv | 31 +++
 rtl/aes_round_counter.sv | 32 +++
 rtl/aes256_enc_round_ctrl.sv | 152 +++++++++++++++
 tb/tb_aes256_enc_round_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/aes_enc_pkg.sv
// Shared definitions for the AES-256 encryption round controller:
// FSM state encoding, addRoundKey source select codes and the default round count.
package aes_enc_pkg;

    // Controller states; one state per datapath stage plus the idle/result states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT_ARK = 3'd1,
        ST_SB       = 3'd2,
        ST_SR       = 3'd3,
        ST_MC       = 3'd4,
        ST_ARK      = 3'd5,
        ST_DONE     = 3'd6
    } enc_state_t;

    // addRoundKey data source select.
    localparam logic [1:0] ARK_SRC_PT = 2'd0;  // plaintext (initial whitening)
    localparam logic [1:0] ARK_SRC_MC = 2'd1;  // mixColumns output (rounds 1..NR-1)
    localparam logic [1:0] ARK_SRC_SR = 2'd2;  // shiftRows output (final round)

    // AES-256 uses 14 cipher rounds.
    localparam int NR_AES256 = 14;

endpackage

// File: rtl/aes256_enc_round_ctrl_if.sv
// Handshake and stage-control bundle between the round controller and its
// surroundings (start/result handshake, key availability, stage strobes).
interface aes256_enc_round_ctrl_if #(
    parameter int KIDX_W = 4
);
    logic              start;
    logic              out_ready;
    logic              key_rdy;
    logic              sb_wr_en;
    logic              sr_wr_en;
    logic              mc_wr_en;
    logic              ark_wr_en;
    logic [1:0]        ark_sel;
    logic [KIDX_W-1:0] key_idx;
    logic              busy;
    logic              out_valid;

    // Controller side: consumes handshake inputs, drives the stage controls.
    modport master (
        input  start, out_ready, key_rdy,
        output sb_wr_en, sr_wr_en, mc_wr_en, ark_wr_en,
        output ark_sel, key_idx, busy, out_valid
    );

    // Datapath / host side.
    modport slave (
        output start, out_ready, key_rdy,
        input  sb_wr_en, sr_wr_en, mc_wr_en, ark_wr_en,
        input  ark_sel, key_idx, busy, out_valid
    );
endinterface

// File: rtl/aes_round_counter.sv
// Round counter for the encryption controller: synchronous clear to 0,
// increment, saturates at NR and flags the terminal round.
module aes_round_counter #(
    parameter int NR = 14,
    parameter int W  = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);
    localparam logic [W-1:0] NR_L = W'(NR);

    logic [W-1:0] count_reg;

    // Count register; saturation keeps the index inside the key schedule.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != NR_L)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == NR_L);

endmodule

// File: rtl/aes256_enc_round_ctrl.sv
// AES-256 encryption round controller. Sequences subBytes, shiftRows,
// mixColumns and addRoundKey stage captures with one-cycle strobes, selects the
// addRoundKey source and round-key index, and skips mixColumns in the final round.
// Optional build macro AES_ENC_KEY_WAIT_EN: stall addRoundKey until key_rdy=1.
module aes256_enc_round_ctrl
    import aes_enc_pkg::*;
#(
    parameter int NR     = NR_AES256,
    parameter int KIDX_W = 4
) (
    input  logic clk,
    input  logic resetn,
    aes256_enc_round_ctrl_if.master bus
);

    enc_state_t        state_reg, state_next;
    logic              cnt_clr, cnt_inc, cnt_last;
    logic [KIDX_W-1:0] round_cnt;
    logic              key_ok;

    logic              sb_wr_en_reg,  sb_wr_en_next;
    logic              sr_wr_en_reg,  sr_wr_en_next;
    logic              mc_wr_en_reg,  mc_wr_en_next;
    logic              ark_phase_reg, ark_phase_next;
    logic [1:0]        ark_sel_reg,   ark_sel_next;
    logic [KIDX_W-1:0] key_idx_reg,   key_idx_next;
    logic              busy_reg,      busy_next;
    logic              out_valid_reg, out_valid_next;

`ifdef AES_ENC_KEY_WAIT_EN
    // The key-wait stall has to act within the cycle key_rdy rises, so the
    // addRoundKey strobe is the registered phase qualified by key_rdy.
    assign key_ok        = bus.key_rdy;
    assign bus.ark_wr_en = ark_phase_reg & bus.key_rdy;
`else
    logic unused_key_rdy;
    assign unused_key_rdy = bus.key_rdy;
    assign key_ok         = 1'b1;
    assign bus.ark_wr_en  = ark_phase_reg;
`endif

    aes_round_counter #(
        .NR (NR),
        .W  (KIDX_W)
    ) u_round_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (round_cnt),
        .last   (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and round-counter control.
    always_comb begin
        state_next = state_reg;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_INIT_ARK;
                    cnt_clr    = 1'b1;
                end
            end
            ST_INIT_ARK: begin
                if (key_ok) begin
                    state_next = ST_SB;
                    cnt_inc    = 1'b1;
                end
            end
            ST_SB: state_next = ST_SR;
            ST_SR: state_next = cnt_last ? ST_ARK : ST_MC;
            ST_MC: state_next = ST_ARK;
            ST_ARK: begin
                if (key_ok) begin
                    if (cnt_last) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SB;
                        cnt_inc    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with the state they describe. The round counter only moves on leaving
    // INIT_ARK/ARK, so its current value is the index for an upcoming ARK.
    always_comb begin
        sb_wr_en_next  = (state_next == ST_SB);
        sr_wr_en_next  = (state_next == ST_SR);
        mc_wr_en_next  = (state_next == ST_MC);
        ark_phase_next = (state_next == ST_INIT_ARK) || (state_next == ST_ARK);
        ark_sel_next   = ARK_SRC_PT;
        key_idx_next   = '0;
        busy_next      = (state_next != ST_IDLE);
        out_valid_next = (state_next == ST_DONE);
        if (state_next == ST_ARK) begin
            ark_sel_next = cnt_last ? ARK_SRC_SR : ARK_SRC_MC;
            key_idx_next = round_cnt;
        end
    end

    // Output registers; reset clears them at once, aborting any operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_wr_en_reg  <= 1'b0;
            sr_wr_en_reg  <= 1'b0;
            mc_wr_en_reg  <= 1'b0;
            ark_phase_reg <= 1'b0;
            ark_sel_reg   <= ARK_SRC_PT;
            key_idx_reg   <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            sb_wr_en_reg  <= sb_wr_en_next;
            sr_wr_en_reg  <= sr_wr_en_next;
            mc_wr_en_reg  <= mc_wr_en_next;
            ark_phase_reg <= ark_phase_next;
            ark_sel_reg   <= ark_sel_next;
            key_idx_reg   <= key_idx_next;
            busy_reg      <= busy_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.sb_wr_en  = sb_wr_en_reg;
    assign bus.sr_wr_en  = sr_wr_en_reg;
    assign bus.mc_wr_en  = mc_wr_en_reg;
    assign bus.ark_sel   = ark_sel_reg;
    assign bus.key_idx   = key_idx_reg;
    assign bus.busy      = busy_reg;
    assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_aes256_enc_round_ctrl.sv
// Directed bench for the AES-256 round controller. Output vector layout:
// {sb, sr, mc, ark, ark_sel[1:0], key_idx[3:0], busy, out_valid}.
module tb_aes256_enc_round_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    aes256_enc_round_ctrl_if #(.KIDX_W(4)) bus ();

    aes256_enc_round_ctrl #(.NR(14), .KIDX_W(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pack(input logic sb, input logic sr, input logic mc,
                                         input logic ark, input logic [1:0] sel,
                                         input logic [3:0] key, input logic busy,
                                         input logic ov);
        return {sb, sr, mc, ark, sel, key, busy, ov};
    endfunction

    // Expected outputs in cycle c after start (no key wait).
    function automatic logic [11:0] base_vec(input int c);
        int r, ph;
        if (c == 1) return pack(0, 0, 0, 1, 2'd0, 4'd0, 1, 0);
        if (c >= 2 && c <= 53) begin
            r  = (c - 2) / 4 + 1;
            ph = (c - 2) % 4;
            case (ph)
                0:       return pack(1, 0, 0, 0, 2'd0, 4'd0, 1, 0);
                1:       return pack(0, 1, 0, 0, 2'd0, 4'd0, 1, 0);
                2:       return pack(0, 0, 1, 0, 2'd0, 4'd0, 1, 0);
                default: return pack(0, 0, 0, 1, 2'd1, 4'(r), 1, 0);
            endcase
        end
        if (c == 54) return pack(1, 0, 0, 0, 2'd0, 4'd0, 1, 0);
        if (c == 55) return pack(0, 1, 0, 0, 2'd0, 4'd0, 1, 0);
        if (c == 56) return pack(0, 0, 0, 1, 2'd2, 4'd14, 1, 0);
        return pack(0, 0, 0, 0, 2'd0, 4'd0, 1, 1);
    endfunction

    // Expected outputs with nwait stall cycles inserted at cycle wait_at.
    function automatic logic [11:0] exp_vec(input int c, input int wait_at, input int nwait);
        logic [11:0] v;
        if (nwait == 0 || c < wait_at) return base_vec(c);
        if (c < wait_at + nwait) begin
            v = base_vec(wait_at);
            v[8] = 1'b0;
            return v;
        end
        return base_vec(c - nwait);
    endfunction

    function automatic logic [11:0] obs_vec();
        return {bus.sb_wr_en, bus.sr_wr_en, bus.mc_wr_en, bus.ark_wr_en,
                bus.ark_sel, bus.key_idx, bus.busy, bus.out_valid};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full encryption: optional stray start at start_at, key_rdy low for
    // kl_n cycles from kl_at, out_ready held low for hold DONE cycles, and
    // optionally start raised together with out_ready in DONE.
    task automatic run_op(input string name, input int start_at, input int kl_at,
                          input int kl_n, input int hold, input bit start_in_done);
        int mc_cnt = 0;
        int ark_cnt = 0;
        int nwait;
        int last_c;
`ifdef AES_ENC_KEY_WAIT_EN
        nwait = kl_n;
`else
        nwait = 0;
`endif
        last_c = 57 + nwait;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= last_c + hold; c++) begin
            bus.start     = (c == start_at) || (start_in_done && c == last_c + hold);
            bus.key_rdy   = !(c >= kl_at && c < kl_at + kl_n);
            bus.out_ready = (c >= last_c + hold);
            #1;
            check($sformatf("%s cyc%0d", name, c), 32'(obs_vec()), 32'(exp_vec(c, kl_at, nwait)));
            if (bus.mc_wr_en)  mc_cnt++;
            if (bus.ark_wr_en) ark_cnt++;
            tick();
        end
        bus.start   = 1'b0;
        bus.key_rdy = 1'b1;
        #1;
        check($sformatf("%s idle after done", name), 32'(obs_vec()), 32'd0);
        tick();
        check($sformatf("%s still idle", name), 32'(obs_vec()), 32'd0);
        check($sformatf("%s mc count", name), 32'(mc_cnt), 32'd13);
        check($sformatf("%s ark count", name), 32'(ark_cnt), 32'd15);
        $display("op %s: mc=%0d ark=%0d done", name, mc_cnt, ark_cnt);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.key_rdy   = 1'b1;

        // Reset state.
        #12;
        check("reset outputs", 32'(obs_vec()), 32'd0);
        resetn = 1'b1;
        tick();
        check("idle after reset", 32'(obs_vec()), 32'd0);
        tick();

        run_op("basic", 0, 0, 0, 0, 1'b0);
        run_op("hold10", 0, 0, 0, 10, 1'b0);
        run_op("start20", 20, 0, 0, 0, 1'b0);
        run_op("keywait", 0, 21, 3, 2, 1'b1);

        // Reset mid-operation at cycle 30.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 30; c++) tick();
        #1;
        check("pre-abort cyc30", 32'(obs_vec()), 32'(exp_vec(30, 0, 0)));
        #2;
        resetn = 1'b0;
        #1;
        check("abort outputs", 32'(obs_vec()), 32'd0);
        #2;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post-abort idle %0d", i), 32'(obs_vec()), 32'd0);
        end
        $display("abort: outputs cleared, idle held");

        run_op("recover", 0, 0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
